// File: rtl/solve_pkg.sv
// solve_pkg: shared status/state enums and seven-segment result glyphs for solve_controller
package solve_pkg;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    BUSY    = 3'd1,
    PASS    = 3'd2,
    FAIL    = 3'd3,
    TIMEOUT = 3'd4
  } solve_status_t;
  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_REQ, S_WAIT, S_DONE} state_t;
  localparam logic [6:0] GLYPH_S    = 7'b0010010;
  localparam logic [6:0] GLYPH_F    = 7'b0001110;
  localparam logic [6:0] GLYPH_T    = 7'b0000111;
  localparam logic [6:0] GLYPH_DASH = 7'b0111111;
endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: 2-flop synchroniser of async d plus prev flop; rise pulses one cycle on each synchronised rising edge
module sync_edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic rise
);
  logic s1, s2, prev;
  always_ff @(posedge clock or posedge reset)
    if (reset) {s1, s2, prev} <= 3'b000;
    else {s1, s2, prev} <= {d, s1, s2};
  assign rise = s2 & ~prev;
endmodule

// File: rtl/solve_controller.sv
// solve_controller: start/done handshake initiator (btn_start,seed_in,grid_done,grid_success in; grid_seed,grid_clear,grid_rq_start,status,elapsed,hex_glyph out)
module solve_controller
  import solve_pkg::*;
#(
  parameter int SEED_W         = 8,
  parameter int CNT_W          = 32,
  parameter int TIMEOUT_CYCLES = 100_000_000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              btn_start,
  input  logic [SEED_W-1:0] seed_in,
  output logic [SEED_W-1:0] grid_seed,
  output logic              grid_clear,
  output logic              grid_rq_start,
  input  logic              grid_done,
  input  logic              grid_success,
  output logic [2:0]        status,
  output logic [CNT_W-1:0]  elapsed,
  output logic [6:0]        hex_glyph
);
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYCLES);
  state_t state, state_n;
  solve_status_t result, result_n, st;
  logic start_edge, accept;
  sync_edge_detect u_sync (
    .clock(clock),
    .reset(reset),
    .d(btn_start),
    .rise(start_edge)
  );
  assign accept = start_edge & (state == S_IDLE | state == S_DONE);
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= S_IDLE;
    else state <= state_n;
  always_comb begin
    state_n  = state;
    result_n = result;
    unique case (state)
      S_IDLE, S_DONE: state_n = accept ? S_CLEAR : state;
      S_CLEAR:        state_n = S_REQ;
      S_REQ:          state_n = S_WAIT;
      S_WAIT: begin
        if (grid_done) begin
          state_n  = S_DONE;
          result_n = grid_success ? PASS : FAIL;
        end else if (elapsed + CNT_W'(1) == TMO) begin
          state_n  = S_DONE;
          result_n = TIMEOUT;
        end
      end
      default:        state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      grid_seed <= '0;
      elapsed   <= '0;
      result    <= IDLE;
    end else begin
      result    <= result_n;
      grid_seed <= accept ? seed_in : grid_seed;
      elapsed   <= state == S_REQ ? '0 : state == S_WAIT ? elapsed + CNT_W'(1) : elapsed;
    end
  assign st            = state == S_IDLE ? IDLE : state == S_DONE ? result : BUSY;
  assign status        = st;
  assign grid_clear    = state == S_CLEAR;
  assign grid_rq_start = state == S_REQ;
  assign hex_glyph     = st == PASS ? GLYPH_S : st == FAIL ? GLYPH_F : st == TIMEOUT ? GLYPH_T : GLYPH_DASH;
endmodule

// File: tb/tb_solve_controller.sv
// tb_solve_controller: directed plus randomized runs of solve_controller against a run-level outcome model
module tb_solve_controller;
  import solve_pkg::*;
  localparam int TMO = 16;
  logic        clock = 0;
  logic        reset = 1;
  logic        btn_start = 0;
  logic [7:0]  seed_in = 0;
  logic [7:0]  grid_seed;
  logic        grid_clear, grid_rq_start;
  logic        grid_done = 0;
  logic        grid_success = 0;
  logic [2:0]  status;
  logic [31:0] elapsed;
  logic [6:0]  hex_glyph;
  int checks = 0;
  int errors = 0;
  int clr_cnt = 0;
  int rq_cnt = 0;
  solve_controller #(.SEED_W(8), .CNT_W(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock),
    .reset(reset),
    .btn_start(btn_start),
    .seed_in(seed_in),
    .grid_seed(grid_seed),
    .grid_clear(grid_clear),
    .grid_rq_start(grid_rq_start),
    .grid_done(grid_done),
    .grid_success(grid_success),
    .status(status),
    .elapsed(elapsed),
    .hex_glyph(hex_glyph)
  );
  always #5 clock = ~clock;
  always @(negedge clock) begin
    if (grid_clear) clr_cnt++;
    if (grid_rq_start) rq_cnt++;
  end
  function automatic logic [6:0] glyph_of(input logic [2:0] s);
    case (s)
      3'd2:    return 7'b0010010;
      3'd3:    return 7'b0001110;
      3'd4:    return 7'b0000111;
      default: return 7'b0111111;
    endcase
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_reset_values(input string tag);
    chk({tag, "_status"}, 32'(status), 32'(IDLE));
    chk({tag, "_glyph"}, 32'(hex_glyph), 32'(7'b0111111));
    chk({tag, "_elapsed"}, elapsed, 0);
    chk({tag, "_seed"}, 32'(grid_seed), 0);
    chk({tag, "_clear"}, 32'(grid_clear), 0);
    chk({tag, "_rq"}, 32'(grid_rq_start), 0);
  endtask
  // d = WAIT cycle in which the grid reports done; d > TMO means the grid never finishes
  task automatic run(input logic [7:0] seed, input int d, input bit succ,
                     input bit hold, input bit toggle, input bit stale);
    int c0, r0, lim;
    logic [2:0] exp_st;
    int exp_el;
    lim = d <= TMO ? d : TMO;
    exp_st = d <= TMO ? (succ ? PASS : FAIL) : TIMEOUT;
    exp_el = lim;
    c0 = clr_cnt;
    r0 = rq_cnt;
    seed_in = seed;
    btn_start = 1;
    repeat (3) @(negedge clock);
    chk("clear_high", 32'(grid_clear), 1);
    chk("busy_in_clear", 32'(status), 32'(BUSY));
    chk("seed_latched", 32'(grid_seed), 32'(seed));
    if (!hold) btn_start = 0;
    if (!stale) grid_done = 0;
    @(negedge clock);
    chk("rq_high", 32'(grid_rq_start), 1);
    chk("clear_dropped", 32'(grid_clear), 0);
    if (stale) grid_done = 0;
    seed_in = 8'($urandom);
    for (int c = 1; c <= lim; c++) begin
      @(negedge clock);
      if (toggle) btn_start = (c < lim - 3) ? 1'((c / 4) % 2) : 1'b0;
      if (c == 1) chk("busy_in_wait", 32'(status), 32'(BUSY));
      if (c == d) begin
        grid_done = 1;
        grid_success = succ;
      end
    end
    @(negedge clock);
    chk("result_status", 32'(status), 32'(exp_st));
    chk("result_elapsed", elapsed, 32'(exp_el));
    chk("result_glyph", 32'(hex_glyph), 32'(glyph_of(exp_st)));
    chk("seed_held", 32'(grid_seed), 32'(seed));
    if (hold) repeat (100) @(negedge clock);
    else repeat (5) @(negedge clock);
    btn_start = 0;
    chk("status_frozen", 32'(status), 32'(exp_st));
    chk("elapsed_frozen", elapsed, 32'(exp_el));
    chk("one_clear", 32'(clr_cnt - c0), 1);
    chk("one_rq", 32'(rq_cnt - r0), 1);
    repeat (4) @(negedge clock);
  endtask
  initial begin
    #2;
    chk_reset_values("reset");
    repeat (2) @(negedge clock);
    reset = 0;
    repeat (3) @(negedge clock);
    run(8'hA5, 10, 1, 0, 0, 0);
    run(8'($urandom), 3, 0, 0, 0, 0);
    run(8'h3C, 5, 1, 0, 0, 0);
    run(8'($urandom), 20, 0, 0, 0, 0);
    run(8'($urandom), 16, 1, 0, 0, 0);
    run(8'($urandom), 12, 1, 1, 0, 0);
    run(8'($urandom), 14, 0, 0, 1, 0);
    run(8'($urandom), 7, 1, 0, 0, 1);
    for (int i = 0; i < 8; i++)
      run(8'($urandom), int'($urandom_range(1, 20)), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    btn_start = 1;
    seed_in = 8'h5A;
    repeat (3) @(negedge clock);
    btn_start = 0;
    grid_done = 0;
    repeat (5) @(negedge clock);
    #2 reset = 1;
    #1 chk_reset_values("async_reset");
    @(negedge clock);
    reset = 0;
    repeat (3) @(negedge clock);
    chk("idle_after_reset", 32'(status), 32'(IDLE));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
